// File: rtl/rol_seq.sv
// -----------------------------------------------------------------------------
// rol_seq -- multi-cycle 32-bit rotate-left / logical-shift-left sequencer.
//
// An accepted request (start while ready) captures the operand, the distance
// and the operation, then moves the accumulator left by up to STEP bit
// positions per BUSY cycle until the full distance has been covered. The
// result is presented on res with valid=1 and held until the consumer acks.
//
// Latency from the accepting edge to valid is floor(shcnt/STEP)+2 edges:
// floor(shcnt/STEP) full-STEP moves, one final partial move (0..STEP-1
// positions), and one settle edge that commits the result into DONE.
//
// Parameters
//   STEP   : maximum distance moved per BUSY cycle; legal values 1,2,4,8,16.
//
// Ports
//   clk    : clock, all state changes on the rising edge.
//   rst_n  : asynchronous active-low reset.
//   start  : operation request, honoured only while ready=1.
//   op     : 0 = rotate left, 1 = logical shift left (zero fill).
//   value  : 32-bit operand, sampled with start.
//   shcnt  : distance 0..31, sampled with start.
//   ack    : consumer accepts the result, honoured only while valid=1.
//   ready  : block idle, start will be accepted.
//   valid  : res holds a completed result.
//   res    : result register (the accumulator).
// -----------------------------------------------------------------------------
module rol_seq #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] value,
  input  logic [4:0]  shcnt,
  input  logic        ack,
  output logic        ready,
  output logic        valid,
  output logic [31:0] res
);

  // 5 bits is enough to hold every legal STEP, including 16.
  localparam logic [4:0] STEP_C = 5'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  // Set by the final partial move; the following BUSY edge commits to DONE.
  // This is the settle slot that makes the latency floor(shcnt/STEP)+2.
  logic        fin_q, fin_d;

  // Move a word left by amt positions. For rotate, the upper half of the
  // doubled word carries the bits that wrapped from bit 31 into bit 0.
  function automatic logic [31:0] move_left(input logic [31:0] word,
                                            input logic [4:0]  amt,
                                            input logic        is_shift);
    logic [63:0] dbl;
    dbl = {word, word} << amt;
    if (is_shift) begin
      move_left = word << amt;
    end else begin
      move_left = dbl[63:32];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fin_q   <= fin_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a hold default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fin_d   = fin_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = value;
          cnt_d   = shcnt;
          op_d    = op;
          fin_d   = 1'b0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q >= STEP_C) begin
          // Subtraction happens only here, so cnt can never underflow.
          acc_d = move_left(acc_q, STEP_C, op_q);
          cnt_d = cnt_q - STEP_C;
        end else begin
          // Remaining distance is below STEP (possibly zero): finish it now.
          acc_d = move_left(acc_q, cnt_q, op_q);
          cnt_d = '0;
          fin_d = 1'b1;
        end
      end

      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        fin_d   = 1'b0;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the state register.
  assign ready = (state_q == IDLE);
  assign valid = (state_q == DONE);
  assign res   = acc_q;

endmodule

// File: tb/tb_rol_seq.sv
// -----------------------------------------------------------------------------
// tb_rol_seq -- directed self-checking bench for rol_seq with STEP=4.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_rol_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] value;
  logic [4:0]  shcnt;
  logic        ack;
  logic        ready;
  logic        valid;
  logic [31:0] res;

  int n_assert = 0;
  int n_fail   = 0;

  rol_seq #(.STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .value (value),
    .shcnt (shcnt),
    .ack   (ack),
    .ready (ready),
    .valid (valid),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; the next rising edge accepts it.
  // Afterwards the operands are scrambled so any late sampling shows up.
  task automatic issue(input logic o, input logic [31:0] v, input logic [4:0] s,
                       input logic hold_start);
    op    = o;
    value = v;
    shcnt = s;
    start = 1'b1;
    @(negedge clk);
    start = hold_start;
    op    = ~o;
    value = ~v;
    shcnt = ~s;
  endtask

  // Called just after the accepting edge; walks lat edges checking that valid
  // rises exactly on edge lat and that ready stays low meanwhile.
  task automatic await_done(input string tag, input int lat, input logic ack_noise);
    for (int k = 1; k <= lat; k++) begin
      ack = (k < lat) ? ack_noise : 1'b0;
      @(negedge clk);
      check({tag, "_valid"}, {31'd0, valid}, {31'd0, (k == lat)});
      check({tag, "_ready"}, {31'd0, ready}, 32'd0);
    end
    ack = 1'b0;
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, "_ack_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_ack_valid"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    value = '0;
    shcnt = '0;
    ack   = 1'b0;

    // Reset state
    #3;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_res",   res,            32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Rotate 0x80000001 by 1: wrapped MSB lands in bit 0
    issue(1'b0, 32'h8000_0001, 5'd1, 1'b0);
    await_done("rol1", 2, 1'b0);
    check("rol1_res", res, 32'h0000_0003);
    do_ack("rol1");

    // Shift 0x12345678 by 4, with ack asserted during BUSY (must be ignored)
    issue(1'b1, 32'h1234_5678, 5'd4, 1'b0);
    await_done("shl4", 3, 1'b1);
    check("shl4_res", res, 32'h2345_6780);
    do_ack("shl4");

    // Rotate 1 by 31 with start held high the whole time
    issue(1'b0, 32'h0000_0001, 5'd31, 1'b1);
    await_done("rol31", 9, 1'b0);
    check("rol31_res", res, 32'h8000_0000);
    @(negedge clk);
    check("rol31_hold_ready", {31'd0, ready}, 32'd0);
    check("rol31_hold_res",   res,            32'h8000_0000);
    start = 1'b0;
    do_ack("rol31");

    // Distance zero, then ack withheld for 10 cycles
    issue(1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0);
    await_done("rol0", 2, 1'b0);
    check("rol0_res", res, 32'hDEAD_BEEF);
    repeat (10) begin
      @(negedge clk);
      check("rol0_hold_valid", {31'd0, valid}, 32'd1);
      check("rol0_hold_res",   res,            32'hDEAD_BEEF);
    end

    // ack, then start in the very next (IDLE) cycle
    do_ack("b2b");
    issue(1'b1, 32'hFFFF_FFFF, 5'd16, 1'b0);
    await_done("b2b", 6, 1'b0);
    check("b2b_res", res, 32'hFFFF_0000);
    do_ack("b2b2");

    // Additional patterns
    issue(1'b1, 32'h8000_0001, 5'd31, 1'b0);
    await_done("shl31", 9, 1'b0);
    check("shl31_res", res, 32'h8000_0000);
    do_ack("shl31");

    issue(1'b0, 32'h1234_5678, 5'd8, 1'b0);
    await_done("rol8", 4, 1'b0);
    check("rol8_res", res, 32'h3456_7812);
    do_ack("rol8");

    issue(1'b0, 32'hF000_0000, 5'd5, 1'b0);
    await_done("rol5", 3, 1'b0);
    check("rol5_res", res, 32'h0000_001E);
    do_ack("rol5");

    issue(1'b1, 32'hF000_000F, 5'd7, 1'b0);
    await_done("shl7", 3, 1'b0);
    check("shl7_res", res, 32'h0000_0780);
    do_ack("shl7");

    // Reset mid-BUSY, off the clock edge
    issue(1'b0, 32'h0000_0001, 5'd31, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_res",   res,            32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("postrst_valid", {31'd0, valid}, 32'd0);
      check("postrst_ready", {31'd0, ready}, 32'd1);
    end

    // Start presented on the first edge after reset release
    rst_n = 1'b0;
    @(negedge clk);
    op    = 1'b0;
    value = 32'h0000_0001;
    shcnt = 5'd0;
    start = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rel_accept_ready", {31'd0, ready}, 32'd0);
    await_done("rel", 2, 1'b0);
    check("rel_res", res, 32'h0000_0001);
    held = res;
    @(negedge clk);
    check("rel_stable", res, held);
    do_ack("rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
